target_hit_detector: RTL and testbench

TARGET_HIT_DETECTOR -- requirements
Module: target_hit_detector

---
 rtl/duck_hunt_pkg.sv | 29 ++
 rtl/pt_debounce.sv | 50 +++++
 rtl/target_hit_detector.sv | 158 +++++++++++++++
 tb/tb_target_hit_detector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/duck_hunt_pkg.sv
// Shared definitions for the duck hunt target logic: target states, target
// count, target index constants and a small hit-counting helper.
package duck_hunt_pkg;

    localparam int NUM_TARGETS = 4;

    localparam int TL = 0;
    localparam int TR = 1;
    localparam int BL = 2;
    localparam int BR = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2,
        ST_MISS  = 2'd3
    } target_state_e;

    // Number of set bits in a per-target hit vector.
    function automatic logic [3:0] count_hits(input logic [NUM_TARGETS-1:0] hits);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            total = total + 4'(hits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/pt_debounce.sv
// One phototransistor channel: 2-flop synchronizer followed by a debouncer
// that exports the accepted stable level and a one-cycle rise strobe.
module pt_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          rise_r;
    logic [CW-1:0] cnt_r;

    // Synchronize the raw level, then accept a new level only after it has
    // differed from the stable one for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                rise_r   <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stable = stable_r;
    assign rise   = rise_r;

endmodule

// File: rtl/target_hit_detector.sv
// Four-target laser hit detector: debounced phototransistor inputs drive a
// per-target IDLE/ARMED/HIT/MISS FSM and a saturating hit counter.
// Optional build macro HIT_TIMEOUT_EN enables the armed-target timeout (MISS).
module target_hit_detector
    import duck_hunt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 100000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_TARGETS-1:0] pt_raw,
    input  logic [NUM_TARGETS-1:0] arm,
    input  logic [NUM_TARGETS-1:0] clear,
    output logic [NUM_TARGETS-1:0] target_led,
    output logic [NUM_TARGETS-1:0] hit_flag,
    output logic [NUM_TARGETS-1:0] hit_pulse,
    output logic [NUM_TARGETS-1:0] miss_flag,
    output logic [7:0]             hit_count
);

    logic [NUM_TARGETS-1:0] stable_s;
    logic [NUM_TARGETS-1:0] rise_s;
    logic [NUM_TARGETS-1:0] hit_ev_s;
    logic [NUM_TARGETS-1:0] hit_pulse_r;
    logic [7:0]             hit_count_r;
    logic [8:0]             count_sum_s;
    target_state_e          state_r  [NUM_TARGETS];
    target_state_e          state_nx [NUM_TARGETS];

`ifdef HIT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_r [NUM_TARGETS];
`endif

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_chan
        pt_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_pt_debounce (
            .clock  (clock),
            .reset  (reset),
            .raw    (pt_raw[g]),
            .stable (stable_s[g]),
            .rise   (rise_s[g])
        );
    end

    // Target state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                state_r[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                state_r[i] <= state_nx[i];
            end
        end
    end

    // Next-state logic; clear beats a hit, and a hit beats a timeout.
    always_comb begin
        hit_ev_s = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            state_nx[i] = state_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (arm[i]) begin
                        state_nx[i] = ST_ARMED;
                    end else begin
                        state_nx[i] = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (clear[i]) begin
                        state_nx[i] = ST_IDLE;
                    end else if (rise_s[i] && stable_s[i]) begin
                        state_nx[i] = ST_HIT;
                        hit_ev_s[i] = 1'b1;
`ifdef HIT_TIMEOUT_EN
                    end else if (timer_r[i] == TIMER_LAST) begin
                        state_nx[i] = ST_MISS;
`endif
                    end else begin
                        state_nx[i] = ST_ARMED;
                    end
                end
                ST_HIT, ST_MISS: begin
                    if (clear[i]) begin
                        state_nx[i] = ST_IDLE;
                    end else begin
                        state_nx[i] = state_r[i];
                    end
                end
                default: begin
                    state_nx[i] = ST_IDLE;
                end
            endcase
        end
    end

`ifdef HIT_TIMEOUT_EN
    // Armed lifetime timers; held at zero outside ARMED so entry starts at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                timer_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                if (state_r[i] == ST_ARMED) begin
                    timer_r[i] <= timer_r[i] + {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    timer_r[i] <= '0;
                end
            end
        end
    end
`endif

    assign count_sum_s = {1'b0, hit_count_r} + {5'd0, count_hits(hit_ev_s)};

    // Hit strobe and saturating hit counter, both aligned with HIT entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_pulse_r <= '0;
            hit_count_r <= 8'd0;
        end else begin
            hit_pulse_r <= hit_ev_s;
            if (count_sum_s > 9'd255) begin
                hit_count_r <= 8'd255;
            end else begin
                hit_count_r <= count_sum_s[7:0];
            end
        end
    end

    // State-decoded output flags.
    always_comb begin
        target_led = '0;
        hit_flag   = '0;
        miss_flag  = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            target_led[i] = (state_r[i] == ST_ARMED);
            hit_flag[i]   = (state_r[i] == ST_HIT);
`ifdef HIT_TIMEOUT_EN
            miss_flag[i]  = (state_r[i] == ST_MISS);
`else
            miss_flag[i]  = 1'b0;
`endif
        end
    end

    assign hit_pulse = hit_pulse_r;
    assign hit_count = hit_count_r;

endmodule

// File: tb/tb_target_hit_detector.sv
// Directed self-checking bench for target_hit_detector (DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=16); the timeout scenario runs when HIT_TIMEOUT_EN is defined.
module tb_target_hit_detector;

    logic       clock;
    logic       reset;
    logic [3:0] pt_raw;
    logic [3:0] arm;
    logic [3:0] clear;
    logic [3:0] target_led;
    logic [3:0] hit_flag;
    logic [3:0] hit_pulse;
    logic [3:0] miss_flag;
    logic [7:0] hit_count;

    int errors;
    int checks;
    logic [3:0] seen;

    target_hit_detector #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pt_raw     (pt_raw),
        .arm        (arm),
        .clear      (clear),
        .target_led (target_led),
        .hit_flag   (hit_flag),
        .hit_pulse  (hit_pulse),
        .miss_flag  (miss_flag),
        .hit_count  (hit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clear everything, let beams fall, then arm mask and fire mask; ends on the pulse cycle.
    task automatic round(input logic [3:0] mask);
        pt_raw = 4'h0;
        clear  = 4'hF;
        step(1);
        clear  = 4'h0;
        step(5);
        pt_raw = mask;
        arm    = mask;
        step(1);
        arm    = 4'h0;
        step(6);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        pt_raw = 4'h0;
        arm    = 4'h0;
        clear  = 4'h0;
        step(2);
        chk("reset_outputs", {target_led, hit_flag, hit_pulse, miss_flag, hit_count}, 32'h0);
        reset = 1'b0;

        // Basic hit on TL: pulse on the 7th edge after raising the beam.
        arm = 4'h1;
        step(1);
        arm = 4'h0;
        chk("tl_armed_led", {28'd0, target_led}, 32'h1);
        pt_raw = 4'h1;
        step(6);
        chk("tl_no_early_pulse", {28'd0, hit_pulse}, 32'h0);
        step(1);
        chk("tl_hit_pulse", {28'd0, hit_pulse}, 32'h1);
        chk("tl_hit_flag", {28'd0, hit_flag}, 32'h1);
        chk("tl_led_off", {28'd0, target_led}, 32'h0);
        chk("tl_count", {24'd0, hit_count}, 32'd1);
        step(1);
        chk("tl_pulse_one_cycle", {28'd0, hit_pulse}, 32'h0);
        pt_raw = 4'h0;
        clear  = 4'h1;
        step(1);
        clear  = 4'h0;
        chk("tl_cleared", {28'd0, hit_flag}, 32'h0);

        // BR glitch of 3 cycles is rejected.
        arm = 4'h8;
        step(1);
        arm = 4'h0;
        pt_raw = 4'h8;
        step(3);
        pt_raw = 4'h0;
        seen = 4'h0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            seen = seen | hit_pulse;
        end
        chk("br_glitch_no_pulse", {28'd0, seen}, 32'h0);
        chk("br_glitch_led", {31'd0, target_led[3]}, 32'h1);

        // TR beam held before arming needs a fall and a new rise.
        pt_raw = 4'h2;
        step(10);
        arm = 4'h2;
        step(1);
        arm = 4'h0;
        seen = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen = seen | hit_pulse;
        end
        chk("tr_held_no_pulse", {28'd0, seen}, 32'h0);
        chk("tr_held_led", {31'd0, target_led[1]}, 32'h1);
        pt_raw = 4'h0;
        step(6);
        pt_raw = 4'h2;
        step(6);
        chk("tr_rerise_no_early", {28'd0, hit_pulse}, 32'h0);
        step(1);
        chk("tr_rerise_pulse", {28'd0, hit_pulse}, 32'h2);
        chk("tr_count", {24'd0, hit_count}, 32'd2);
        pt_raw = 4'h0;
        clear  = 4'hF;
        step(1);
        clear  = 4'h0;
        step(8);

        // Clear on BL in the very cycle its hit would land.
        arm    = 4'h4;
        pt_raw = 4'h4;
        step(1);
        arm    = 4'h0;
        step(5);
        clear  = 4'h4;
        step(1);
        clear  = 4'h0;
        chk("bl_clear_no_pulse", {28'd0, hit_pulse}, 32'h0);
        chk("bl_clear_idle", {28'd0, target_led | hit_flag}, 32'h0);
        chk("bl_clear_count", {24'd0, hit_count}, 32'd2);
        step(1);
        chk("bl_clear_no_late", {28'd0, hit_pulse}, 32'h0);

        // Reset in the middle of a TL debounce.
        arm = 4'h1;
        step(1);
        arm = 4'h0;
        pt_raw = 4'h5;
        step(3);
        reset = 1'b1;
        step(1);
        chk("midreset_outputs", {target_led, hit_flag, hit_pulse, miss_flag, hit_count}, 32'h0);
        reset = 1'b0;
        seen = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen = seen | hit_pulse;
        end
        chk("midreset_no_pulse", {28'd0, seen}, 32'h0);
        chk("midreset_idle", {24'd0, target_led, hit_count[3:0]}, 32'h0);

        // All four at once, then drive the counter into saturation.
        round(4'hF);
        chk("all_pulse", {28'd0, hit_pulse}, 32'hF);
        chk("all_count", {24'd0, hit_count}, 32'd4);
        for (int r = 0; r < 61; r++) begin
            round(4'hF);
        end
        chk("count_248", {24'd0, hit_count}, 32'd248);
        for (int r = 0; r < 3; r++) begin
            round(4'h3);
        end
        chk("count_254", {24'd0, hit_count}, 32'd254);
        round(4'hF);
        chk("sat_pulse", {28'd0, hit_pulse}, 32'hF);
        chk("sat_255", {24'd0, hit_count}, 32'd255);
        round(4'h1);
        chk("sat_hold", {24'd0, hit_count}, 32'd255);

`ifdef HIT_TIMEOUT_EN
        // TL times out after 16 armed cycles without a beam.
        pt_raw = 4'h0;
        clear  = 4'hF;
        step(1);
        clear  = 4'h0;
        step(6);
        arm = 4'h1;
        step(1);
        arm = 4'h0;
        step(15);
        chk("to_not_yet", {28'd0, miss_flag}, 32'h0);
        chk("to_still_lit", {28'd0, target_led}, 32'h1);
        step(1);
        chk("to_miss", {28'd0, miss_flag}, 32'h1);
        chk("to_led_off", {28'd0, target_led}, 32'h0);
        clear = 4'h1;
        step(1);
        clear = 4'h0;
        chk("to_cleared", {28'd0, miss_flag | target_led}, 32'h0);
`else
        chk("miss_tied_low", {28'd0, miss_flag}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
